// File: rtl/spider_game_pkg.sv
// Shared definitions for the spider game pipeline: screen geometry,
// sprite size, coordinate width and the hit-detector FSM states.
package spider_game_pkg;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned SPIDER_SIZE = 32;
    localparam int unsigned COORD_W     = 10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } hit_state_t;

endpackage

// File: rtl/spider_hit_detector_if.sv
// Bundle of the hit detector's frame inputs (spider/bullet state, frame tick)
// and its kill/score/explosion outputs. master = upstream stages, slave = detector.
interface spider_hit_detector_if #(
    parameter int unsigned N_SPIDERS = 4,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned SCORE_W   = 16
);

    logic                           frame_tick;
    logic [N_SPIDERS*COORD_W-1:0]   spider_x_flat;
    logic [N_SPIDERS*COORD_W-1:0]   spider_y_flat;
    logic [N_SPIDERS-1:0]           spider_alive_flat;
    logic [COORD_W-1:0]             bullet_x;
    logic [COORD_W-1:0]             bullet_y;
    logic                           bullet_active;
    logic [N_SPIDERS-1:0]           kill_mask;
    logic                           bullet_consume;
    logic [SCORE_W-1:0]             score;
    logic [N_SPIDERS-1:0]           explode_active;
    logic                           busy;
    logic                           overrun;

    modport master (
        output frame_tick, spider_x_flat, spider_y_flat, spider_alive_flat,
               bullet_x, bullet_y, bullet_active,
        input  kill_mask, bullet_consume, score, explode_active, busy, overrun
    );

    modport slave (
        input  frame_tick, spider_x_flat, spider_y_flat, spider_alive_flat,
               bullet_x, bullet_y, bullet_active,
        output kill_mask, bullet_consume, score, explode_active, busy, overrun
    );

endinterface

// File: rtl/spider_rect_overlap.sv
// Axis-aligned rectangle overlap test. Rectangle A is A_W x A_H at (ax,ay),
// rectangle B is B_W x B_H at (bx,by). Sums are one bit wider than the
// coordinates so rectangles near the top of the coordinate range never wrap.
module spider_rect_overlap #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned A_W     = 32,
    parameter int unsigned A_H     = 32,
    parameter int unsigned B_W     = 4,
    parameter int unsigned B_H     = 8
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               overlap
);

    localparam int unsigned W = COORD_W + 1;

    logic [W-1:0] ax_w, ay_w, bx_w, by_w;
    logic         x_ovl, y_ovl;

    // Strict-inequality overlap on both axes; touching edges do not overlap.
    always_comb begin
        ax_w    = {1'b0, ax};
        ay_w    = {1'b0, ay};
        bx_w    = {1'b0, bx};
        by_w    = {1'b0, by};
        x_ovl   = (bx_w < ax_w + W'(A_W)) && (ax_w < bx_w + W'(B_W));
        y_ovl   = (by_w < ay_w + W'(A_H)) && (ay_w < by_w + W'(B_H));
        overlap = x_ovl && y_ovl;
    end

endmodule

// File: rtl/spider_hit_detector.sv
// Per-frame bullet/spider collision stage. Snapshots the spider and bullet
// state on frame_tick, scans one spider per clock, and reports the
// lowest-index hit as a one-cycle kill pulse plus a saturating score.
// Optional feature macro: SPIDER_HIT_EXPLODE_EN (per-spider explosion timers;
// exploding spiders cannot be hit). Without it explode_active is tied low.
module spider_hit_detector #(
    parameter int unsigned N_SPIDERS      = 4,
    parameter int unsigned COORD_W        = spider_game_pkg::COORD_W,
    parameter int unsigned SPIDER_SIZE    = spider_game_pkg::SPIDER_SIZE,
    parameter int unsigned BULLET_W       = 4,
    parameter int unsigned BULLET_H       = 8,
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned EXPLODE_FRAMES = 16
) (
    input  logic                 clk25,
    input  logic                 reset_n,
    spider_hit_detector_if.slave hit_if
);

    import spider_game_pkg::*;

    localparam int unsigned IDX_W = (N_SPIDERS > 1) ? $clog2(N_SPIDERS) : 1;
    localparam int unsigned CNT_W = $clog2(EXPLODE_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPIDERS - 1);

    hit_state_t           state, state_nxt;
    logic                 tick_q;
    logic [COORD_W-1:0]   snap_x [N_SPIDERS];
    logic [COORD_W-1:0]   snap_y [N_SPIDERS];
    logic [N_SPIDERS-1:0] snap_alive;
    logic [N_SPIDERS-1:0] snap_explode;
    logic [COORD_W-1:0]   snap_bx, snap_by;
    logic                 snap_active;
    logic [IDX_W-1:0]     idx, hit_idx, sel_idx;
    logic                 hit_found, overlap, hit_now, fire;
    logic [N_SPIDERS-1:0] kill_mask_q, explode_vec;
    logic                 bullet_consume_q, busy_q, overrun_q;
    logic [SCORE_W-1:0]   score_q;

    spider_rect_overlap #(
        .COORD_W (COORD_W),
        .A_W     (SPIDER_SIZE),
        .A_H     (SPIDER_SIZE),
        .B_W     (BULLET_W),
        .B_H     (BULLET_H)
    ) u_overlap (
        .ax      (snap_x[idx]),
        .ay      (snap_y[idx]),
        .bx      (snap_bx),
        .by      (snap_by),
        .overlap (overlap)
    );

    // Hit test for the spider under scan and the report trigger.
    // The report is registered on the last SCAN edge so the pulse is
    // visible during the REPORT cycle; the last spider's hit is folded in here.
    always_comb begin
        hit_now = snap_active && snap_alive[idx] && !snap_explode[idx] && overlap;
        fire    = (state == SCAN) && (idx == LAST_IDX) && (hit_found || hit_now);
        sel_idx = hit_found ? hit_idx : idx;
    end

    // FSM state register.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick_q) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tick register, snapshot capture, scan bookkeeping and registered outputs.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            tick_q           <= 1'b0;
            for (int unsigned i = 0; i < N_SPIDERS; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
            snap_alive       <= '0;
            snap_explode     <= '0;
            snap_bx          <= '0;
            snap_by          <= '0;
            snap_active      <= 1'b0;
            idx              <= '0;
            hit_idx          <= '0;
            hit_found        <= 1'b0;
            kill_mask_q      <= '0;
            bullet_consume_q <= 1'b0;
            score_q          <= '0;
            busy_q           <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            tick_q           <= hit_if.frame_tick;
            busy_q           <= (state_nxt != IDLE);
            kill_mask_q      <= '0;
            bullet_consume_q <= 1'b0;
            if (tick_q && state != IDLE) overrun_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick_q) begin
                        for (int unsigned i = 0; i < N_SPIDERS; i++) begin
                            snap_x[i] <= hit_if.spider_x_flat[i*COORD_W +: COORD_W];
                            snap_y[i] <= hit_if.spider_y_flat[i*COORD_W +: COORD_W];
                        end
                        snap_alive   <= hit_if.spider_alive_flat;
                        snap_explode <= explode_vec;
                        snap_bx      <= hit_if.bullet_x;
                        snap_by      <= hit_if.bullet_y;
                        snap_active  <= hit_if.bullet_active;
                        idx          <= '0;
                        hit_found    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hit_now && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_idx   <= idx;
                    end
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                    if (fire) begin
                        kill_mask_q      <= N_SPIDERS'(1) << sel_idx;
                        bullet_consume_q <= 1'b1;
                        if (score_q != '1) score_q <= score_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPIDER_HIT_EXPLODE_EN
    logic [CNT_W-1:0] explode_cnt [N_SPIDERS];

    // Explosion timers: load on kill, count down once per frame tick.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_SPIDERS; i++) explode_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SPIDERS; i++) begin
                if (fire && sel_idx == IDX_W'(i))
                    explode_cnt[i] <= CNT_W'(EXPLODE_FRAMES);
                else if (tick_q && explode_cnt[i] != '0)
                    explode_cnt[i] <= explode_cnt[i] - 1'b1;
            end
        end
    end

    // A spider is exploding while its timer is nonzero.
    always_comb begin
        for (int unsigned i = 0; i < N_SPIDERS; i++) explode_vec[i] = (explode_cnt[i] != '0);
    end
`else
    // No explosion tracking in this build.
    always_comb begin
        explode_vec = '0;
    end
`endif

    assign hit_if.kill_mask      = kill_mask_q;
    assign hit_if.bullet_consume = bullet_consume_q;
    assign hit_if.score          = score_q;
    assign hit_if.explode_active = explode_vec;
    assign hit_if.busy           = busy_q;
    assign hit_if.overrun        = overrun_q;

endmodule

// File: tb/tb_spider_hit_detector.sv
// Directed bench for spider_hit_detector. A scoreboard queue holds the
// expected report of each accepted frame; a monitor pops it when busy falls.
// A second instance with a 2-bit score exercises score saturation.
module tb_spider_hit_detector;

`ifdef SPIDER_HIT_EXPLODE_EN
    localparam bit EXP_ON = 1'b1;
`else
    localparam bit EXP_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  kill;
        logic        consume;
        logic [15:0] score;
    } exp_t;

    logic clk25 = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] exp_score = '0;
    logic [1:0]  small_score = '0;

    spider_hit_detector_if #(.N_SPIDERS(4), .COORD_W(10), .SCORE_W(16)) bus ();
    spider_hit_detector_if #(.N_SPIDERS(4), .COORD_W(10), .SCORE_W(2))  bus_s ();

    spider_hit_detector #(.N_SPIDERS(4), .SCORE_W(16)) dut (
        .clk25   (clk25),
        .reset_n (reset_n),
        .hit_if  (bus)
    );

    spider_hit_detector #(.N_SPIDERS(4), .SCORE_W(2)) dut_small (
        .clk25   (clk25),
        .reset_n (reset_n),
        .hit_if  (bus_s)
    );

    assign bus_s.frame_tick        = bus.frame_tick;
    assign bus_s.spider_x_flat     = bus.spider_x_flat;
    assign bus_s.spider_y_flat     = bus.spider_y_flat;
    assign bus_s.spider_alive_flat = bus.spider_alive_flat;
    assign bus_s.bullet_x          = bus.bullet_x;
    assign bus_s.bullet_y          = bus.bullet_y;
    assign bus_s.bullet_active     = bus.bullet_active;

    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic place(input int unsigned i, input int unsigned x, input int unsigned y, input bit alive);
        bus.spider_x_flat[i*10 +: 10] = 10'(x);
        bus.spider_y_flat[i*10 +: 10] = 10'(y);
        bus.spider_alive_flat[i]      = alive;
    endtask

    task automatic bullet(input int unsigned x, input int unsigned y, input bit act);
        bus.bullet_x      = 10'(x);
        bus.bullet_y      = 10'(y);
        bus.bullet_active = act;
    endtask

    // Push expectation, pulse frame_tick; returns at the negedge after edge E.
    task automatic tick_frame(input logic [3:0] exp_kill);
        exp_t e;
        if (exp_kill != 4'b0000 && exp_score != 16'hFFFF) exp_score = exp_score + 16'd1;
        if (exp_kill != 4'b0000 && small_score != 2'd3) small_score = small_score + 2'd1;
        e.kill    = exp_kill;
        e.consume = (exp_kill != 4'b0000);
        e.score   = exp_score;
        sb.push_back(e);
        @(negedge clk25) bus.frame_tick = 1'b1;
        @(posedge clk25);
        @(negedge clk25) bus.frame_tick = 1'b0;
    endtask

    task automatic frame(input logic [3:0] exp_kill);
        tick_frame(exp_kill);
        repeat (7) @(negedge clk25);
    endtask

    // Scoreboard monitor: the report is the sample just before busy falls.
    logic        prev_busy = 1'b0;
    logic [3:0]  prev_kill = '0;
    logic        prev_consume = 1'b0;
    logic [15:0] prev_score = '0;
    always @(negedge clk25) begin
        exp_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !bus.busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_unexpected_scan observed=scan expected=none");
                end else begin
                    e = sb.pop_front();
                    check("sb_kill", prev_kill, e.kill);
                    check("sb_consume", prev_consume, e.consume);
                    check("sb_score", prev_score, e.score);
                    check("sb_kill_one_cycle", bus.kill_mask, 4'b0000);
                end
            end
            prev_busy    = bus.busy;
            prev_kill    = bus.kill_mask;
            prev_consume = bus.bullet_consume;
            prev_score   = bus.score;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] any_kill;
        reset_n               = 1'b0;
        bus.frame_tick        = 1'b0;
        bus.spider_x_flat     = '0;
        bus.spider_y_flat     = '0;
        bus.spider_alive_flat = '0;
        for (int unsigned i = 0; i < 4; i++) place(i, 600, 440, 1'b0);
        bullet(0, 0, 1'b0);
        repeat (3) @(negedge clk25);
        check("rst_kill", bus.kill_mask, 4'b0000);
        check("rst_consume", bus.bullet_consume, 1'b0);
        check("rst_score", bus.score, 16'h0000);
        check("rst_explode", bus.explode_active, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk25);

        // Basic hit on spider 0 with cycle-exact timing.
        place(0, 128, 100, 1'b1);
        bullet(140, 110, 1'b1);
        tick_frame(4'b0001);
        @(negedge clk25);
        check("busy_rise", bus.busy, 1'b1);
        repeat (3) @(negedge clk25);
        check("kill_not_early", bus.kill_mask, 4'b0000);
        @(negedge clk25);
        check("kill_t1", bus.kill_mask, 4'b0001);
        check("consume_t1", bus.bullet_consume, 1'b1);
        check("score_t1", bus.score, 16'd1);
        check("busy_in_report", bus.busy, 1'b1);
        @(negedge clk25);
        check("kill_cleared", bus.kill_mask, 4'b0000);
        check("busy_fall", bus.busy, 1'b0);
        check("explode_load", bus.explode_active, EXP_ON ? 4'b0001 : 4'b0000);
        repeat (2) @(negedge clk25);

        // Same geometry while spider 0 explodes.
        frame(EXP_ON ? 4'b0000 : 4'b0001);

        // Inactive bullet over spider 0; timer runs down one per frame.
        bullet(140, 110, 1'b0);
        repeat (14) frame(4'b0000);
        check("explode_last", bus.explode_active, EXP_ON ? 4'b0001 : 4'b0000);
        frame(4'b0000);
        check("explode_done", bus.explode_active, 4'b0000);

        // Two overlapping spiders: lowest index wins.
        place(0, 128, 100, 1'b0);
        place(1, 288, 50, 1'b1);
        place(2, 290, 50, 1'b1);
        bullet(295, 60, 1'b1);
        frame(4'b0010);

        // Dead spiders are not hit.
        place(1, 288, 50, 1'b0);
        place(2, 290, 50, 1'b0);
        frame(4'b0000);

        // X adjacency.
        place(3, 128, 300, 1'b1);
        bullet(160, 300, 1'b1);
        frame(4'b0000);
        bullet(125, 300, 1'b1);
        frame(4'b1000);

        // Y adjacency.
        place(3, 600, 440, 1'b0);
        place(0, 400, 300, 1'b1);
        bullet(410, 292, 1'b1);
        frame(4'b0000);
        bullet(410, 293, 1'b1);
        frame(4'b0001);

        // Top of coordinate range: sums must not wrap.
        place(0, 400, 300, 1'b0);
        place(2, 1000, 0, 1'b1);
        bullet(1020, 10, 1'b1);
        frame(4'b0100);

        // frame_tick while busy.
        place(2, 1000, 0, 1'b0);
        bullet(0, 0, 1'b0);
        check("overrun_clear", bus.overrun, 1'b0);
        tick_frame(4'b0000);
        repeat (2) @(negedge clk25);
        bus.frame_tick = 1'b1;
        @(posedge clk25);
        @(negedge clk25) bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk25);
        check("overrun_set", bus.overrun, 1'b1);
        check("overrun_busy_done", bus.busy, 1'b0);
        frame(4'b0000);
        check("overrun_sticky", bus.overrun, 1'b1);

        // Reset in the middle of a scan.
        place(1, 288, 50, 1'b1);
        bullet(295, 60, 1'b1);
        @(negedge clk25) bus.frame_tick = 1'b1;
        @(posedge clk25);
        @(negedge clk25) bus.frame_tick = 1'b0;
        repeat (3) @(posedge clk25);
        #5 reset_n = 1'b0;
        @(negedge clk25);
        check("mid_rst_kill", bus.kill_mask, 4'b0000);
        check("mid_rst_consume", bus.bullet_consume, 1'b0);
        check("mid_rst_score", bus.score, 16'h0000);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_overrun", bus.overrun, 1'b0);
        check("mid_rst_explode", bus.explode_active, 4'b0000);
        exp_score   = '0;
        small_score = '0;
        repeat (2) @(negedge clk25);
        reset_n = 1'b1;
        any_kill = '0;
        repeat (8) begin
            @(negedge clk25);
            any_kill = any_kill | bus.kill_mask;
        end
        check("mid_rst_no_pulse", any_kill, 4'b0000);

        // Saturation on the 2-bit score instance; main score keeps counting.
        for (int unsigned i = 0; i < 4; i++) place(i, 100 + 100 * i, 200, 1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            bullet(110 + 100 * i, 210, 1'b1);
            frame(4'(1 << i));
        end
        check("sat_small_score", bus_s.score, small_score);
        check("sat_small_value", bus_s.score, 2'd3);
        check("sat_main_score", bus.score, 16'd4);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
